// File: rtl/mod_updown_counter.sv
// rtl/mod_updown_counter.sv - Up/down counter with programmable terminal value, wrap or saturate, boundary pulses and sticky flag
module mod_updown_counter #(
  parameter int unsigned      WIDTH     = 8,
  parameter longint unsigned  MAX_COUNT = (64'd1 << WIDTH) - 64'd1,
  parameter bit               SATURATE  = 1'b0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             up_dn,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  input  logic             ovf_clr,
  output logic [WIDTH-1:0] count_out,
  output logic             overflow,
  output logic             underflow,
  output logic             ovf_sticky,
  output logic             terminal
);

  localparam logic [WIDTH-1:0] MAX_W   = WIDTH'(MAX_COUNT);
  localparam logic [WIDTH:0]   MAX_EXT = {1'b0, MAX_W};

  logic [WIDTH-1:0] count_q, count_d;
  logic             overflow_q, overflow_d;
  logic             underflow_q, underflow_d;
  logic             sticky_q, sticky_d;

  logic [WIDTH:0] count_ext;
  logic [WIDTH:0] count_inc;
  logic [WIDTH:0] count_dec;

  // One extra bit keeps the boundary checks exact when MAX_COUNT fills the full width.
  assign count_ext = {1'b0, count_q};
  assign count_inc = count_ext + {{WIDTH{1'b0}}, 1'b1};
  assign count_dec = count_ext - {{WIDTH{1'b0}}, 1'b1};

  always_comb begin
    count_d     = count_q;
    overflow_d  = 1'b0;
    underflow_d = 1'b0;
    sticky_d    = sticky_q;

    if (load) begin
      count_d = (load_val > MAX_W) ? MAX_W : load_val;
    end else if (en) begin
      if (up_dn) begin
        if (count_inc > MAX_EXT) begin
          overflow_d = 1'b1;
          count_d    = SATURATE ? MAX_W : '0;
        end else begin
          count_d = count_inc[WIDTH-1:0];
        end
      end else begin
        if (count_dec[WIDTH]) begin
          underflow_d = 1'b1;
          count_d     = SATURATE ? '0 : MAX_W;
        end else begin
          count_d = count_dec[WIDTH-1:0];
        end
      end
    end

    // A new event beats a simultaneous clear.
    if (overflow_d || underflow_d) begin
      sticky_d = 1'b1;
    end else if (ovf_clr) begin
      sticky_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      count_q     <= '0;
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
      sticky_q    <= 1'b0;
    end else begin
      count_q     <= count_d;
      overflow_q  <= overflow_d;
      underflow_q <= underflow_d;
      sticky_q    <= sticky_d;
    end
  end

  assign count_out  = count_q;
  assign overflow   = overflow_q;
  assign underflow  = underflow_q;
  assign ovf_sticky = sticky_q;
  assign terminal   = up_dn ? (count_q == MAX_W) : (count_q == '0);

endmodule

// File: tb/tb_mod_updown_counter.sv
// tb/tb_mod_updown_counter.sv - Directed checks for mod_updown_counter in wrap, saturate and default-width configurations
module tb_mod_updown_counter;

  logic       clk = 1'b0;
  logic       rst, en, up_dn, load, ovf_clr;
  logic [7:0] load_val;

  logic [3:0] a_cnt, b_cnt;
  logic [7:0] c_cnt;
  logic       a_ovf, a_unf, a_stk, a_term;
  logic       b_ovf, b_unf, b_stk, b_term;
  logic       c_ovf, c_unf, c_stk, c_term;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  mod_updown_counter #(.WIDTH(4), .MAX_COUNT(9), .SATURATE(1'b0)) u_wrap (
    .clk(clk), .rst(rst), .en(en), .up_dn(up_dn), .load(load), .load_val(load_val[3:0]),
    .ovf_clr(ovf_clr), .count_out(a_cnt), .overflow(a_ovf), .underflow(a_unf),
    .ovf_sticky(a_stk), .terminal(a_term)
  );

  mod_updown_counter #(.WIDTH(4), .MAX_COUNT(9), .SATURATE(1'b1)) u_sat (
    .clk(clk), .rst(rst), .en(en), .up_dn(up_dn), .load(load), .load_val(load_val[3:0]),
    .ovf_clr(ovf_clr), .count_out(b_cnt), .overflow(b_ovf), .underflow(b_unf),
    .ovf_sticky(b_stk), .terminal(b_term)
  );

  mod_updown_counter u_dflt (
    .clk(clk), .rst(rst), .en(en), .up_dn(up_dn), .load(load), .load_val(load_val),
    .ovf_clr(ovf_clr), .count_out(c_cnt), .overflow(c_ovf), .underflow(c_unf),
    .ovf_sticky(c_stk), .terminal(c_term)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic r, input logic e, input logic u, input logic l,
                       input logic [7:0] lv, input logic c);
    rst = r; en = e; up_dn = u; load = l; load_val = lv; ovf_clr = c;
  endtask

  initial begin
    drive(1, 0, 1, 0, 8'd0, 0);
    #1;
    step();
    check("rst_cnt", a_cnt, 0);
    check("rst_ovf", a_ovf, 0);
    check("rst_unf", a_unf, 0);
    check("rst_stk", a_stk, 0);
    check("rst_term_up", a_term, 0);
    check("rst_dflt_cnt", c_cnt, 0);
    up_dn = 0;
    #1;
    check("rst_term_dn", a_term, 1);

    // wrap config counting up through 9 -> 0
    drive(0, 1, 1, 0, 8'd0, 0);
    for (int i = 1; i <= 12; i++) begin
      step();
      check("up_cnt", a_cnt, i % 10);
      check("up_ovf", a_ovf, (i == 10));
      check("up_stk", a_stk, (i >= 10));
      if (i == 9) check("up_term9", a_term, 1);
    end

    // wrap config counting down from 0
    drive(1, 0, 0, 0, 8'd0, 0);
    step();
    drive(0, 1, 0, 0, 8'd0, 0);
    for (int i = 0; i < 3; i++) begin
      step();
      check("dn_cnt", a_cnt, 9 - i);
      check("dn_unf", a_unf, (i == 0));
    end

    // saturate at 0 going down
    drive(1, 0, 0, 0, 8'd0, 0);
    step();
    drive(0, 1, 0, 0, 8'd0, 0);
    step();
    check("sat_dn_cnt", b_cnt, 0);
    check("sat_dn_unf", b_unf, 1);
    check("sat_dn_stk", b_stk, 1);

    // saturate at 9 going up, pulse every held cycle
    drive(0, 0, 1, 1, 8'd9, 0);
    step();
    check("sat_load", b_cnt, 9);
    drive(0, 1, 1, 0, 8'd0, 0);
    for (int i = 0; i < 3; i++) begin
      step();
      check("sat_up_cnt", b_cnt, 9);
      check("sat_up_ovf", b_ovf, 1);
    end
    up_dn = 0;
    step();
    check("sat_back_cnt", b_cnt, 8);
    check("sat_back_ovf", b_ovf, 0);

    // load clamping and load priority over en
    drive(0, 0, 1, 1, 8'd14, 0);
    step();
    check("clamp_cnt", a_cnt, 9);
    drive(0, 1, 1, 1, 8'd3, 0);
    step();
    check("load_pri_cnt", a_cnt, 3);
    check("load_pri_ovf", a_ovf, 0);

    // sticky: set wins over clear, then clear
    drive(1, 0, 1, 0, 8'd0, 0);
    step();
    drive(0, 0, 1, 1, 8'd9, 0);
    step();
    drive(0, 1, 1, 0, 8'd0, 1);
    step();
    check("clr_same_ovf", a_ovf, 1);
    check("clr_same_stk", a_stk, 1);
    drive(0, 0, 1, 0, 8'd0, 1);
    step();
    check("clr_next_stk", a_stk, 0);
    check("clr_next_ovf", a_ovf, 0);

    // reset coinciding with a wrap
    drive(0, 0, 1, 1, 8'd9, 0);
    step();
    drive(1, 1, 1, 0, 8'd0, 0);
    step();
    check("rstwrap_cnt", a_cnt, 0);
    check("rstwrap_ovf", a_ovf, 0);
    check("rstwrap_stk", a_stk, 0);
    drive(0, 1, 1, 0, 8'd0, 0);
    step();
    check("resume_cnt", a_cnt, 1);

    // default 8-bit config wraps 255 -> 0
    drive(0, 0, 1, 1, 8'd255, 0);
    step();
    check("dflt_load", c_cnt, 255);
    check("dflt_term", c_term, 1);
    drive(0, 1, 1, 0, 8'd0, 0);
    step();
    check("dflt_wrap_cnt", c_cnt, 0);
    check("dflt_wrap_ovf", c_ovf, 1);
    check("dflt_wrap_stk", c_stk, 1);
    en = 0;
    step();
    check("dflt_pulse_end", c_ovf, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
